// File: rtl/mem_accum_pkg.sv
// Shared types for the memory accumulate engine: FSM state encoding and mode codes.
package mem_accum_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StAcc,
        StWrite,
        StDone
    } state_e;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/mem_accum_alu.sv
// Combinational accumulate step: unsigned sum with carry-out, or unsigned maximum.
// Defining MEM_ACCUM_SAT_EN makes the sum saturate to all-ones on carry instead of wrapping.
module mem_accum_alu
    import mem_accum_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              mode_i,
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, acc_i} + {1'b0, data_i};

    always_comb begin
        result_o = acc_i;
        carry_o  = 1'b0;
        if (mode_i == MODE_SUM) begin
            carry_o = sum[DATA_W];
`ifdef MEM_ACCUM_SAT_EN
            result_o = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
            result_o = sum[DATA_W-1:0];
`endif
        end else if (data_i > acc_i) begin
            result_o = data_i;
        end
    end

endmodule

// File: rtl/mem_accum_engine.sv
// Reads Count words from BaseAddr, sums or maxes them, writes the result to DestAddr.
// Saturating sum is selected at build time with MEM_ACCUM_SAT_EN (see mem_accum_alu).
module mem_accum_engine
    import mem_accum_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   count_i,
    input  logic [ADDR_W-1:0] dest_addr_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] data_out_i,
    output logic [DATA_W-1:0] data_in_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_enable_o,
    output logic              write_enable_o,
    output logic              ready_o,
    output logic              done_o,
    output logic              overflow_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              mode_q, mode_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    mem_accum_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .mode_i   (mode_q),
        .acc_i    (acc_q),
        .data_i   (data_out_i),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ptr_q   <= '0;
            rem_q   <= '0;
            dest_q  <= '0;
            mode_q  <= MODE_SUM;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            dest_q  <= dest_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        ptr_d          = ptr_q;
        rem_d          = rem_q;
        dest_d         = dest_q;
        mode_d         = mode_q;
        ovf_d          = ovf_q;
        address_o      = '0;
        read_enable_o  = 1'b0;
        write_enable_o = 1'b0;
        ready_o        = 1'b0;
        done_o         = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (start_i) begin
                    acc_d   = '0;
                    ptr_d   = base_addr_i;
                    rem_d   = count_i;
                    dest_d  = dest_addr_i;
                    mode_d  = mode_i;
                    ovf_d   = 1'b0;
                    state_d = (count_i == '0) ? StWrite : StRead;
                end
            end
            StRead: begin
                read_enable_o = 1'b1;
                address_o     = ptr_q;
                state_d       = StAcc;
            end
            StAcc: begin
                // Carry is only ever raised in sum mode, so max mode never sets the flag.
                acc_d   = alu_result;
                ovf_d   = ovf_q | alu_carry;
                ptr_d   = ptr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q > (ADDR_W + 1)'(1)) ? StRead : StWrite;
            end
            StWrite: begin
                write_enable_o = 1'b1;
                address_o      = dest_q;
                state_d        = StDone;
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_in_o  = acc_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_mem_accum_engine.sv
// Randomised bench for mem_accum_engine with a behavioural memory and per-cycle reference model.
module tb_mem_accum_engine;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base  = '0;
    logic [AW:0]   count = '0;
    logic [AW-1:0] dest  = '0;
    logic          mode  = 1'b0;
    logic [DW-1:0] rdata;
    logic [DW-1:0] wdata;
    logic [AW-1:0] addr;
    logic          re, we, ready, done, ovf;

    logic [DW-1:0] mem [DEPTH];
    int            re_cnt = 0;
    int            we_cnt = 0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    mem_accum_engine #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .base_addr_i    (base),
        .count_i        (count),
        .dest_addr_i    (dest),
        .mode_i         (mode),
        .data_out_i     (rdata),
        .data_in_o      (wdata),
        .address_o      (addr),
        .read_enable_o  (re),
        .write_enable_o (we),
        .ready_o        (ready),
        .done_o         (done),
        .overflow_o     (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous memory; read data is garbage except the cycle after a read strobe.
    initial begin
        rdata <= '0;
        forever begin
            @(posedge clk);
            if (we) begin
                mem[addr] = wdata;
                we_cnt++;
            end
            if (re) begin
                rdata <= mem[addr];
                re_cnt++;
            end else begin
                rdata <= DW'($urandom);
            end
        end
    end

    // Reference model: op timeline relative to the accept cycle, results by plain arithmetic.
    initial begin : model
        bit m_valid, m_busy, m_mode, m_ovf, o;
        int m_r, m_n, m_base, m_dest, m_acc, a, s, d, kc;
        int e_rdy, e_done, e_re, e_we, e_addr, e_din, e_ovf;
        int acc_seq [0:DEPTH];
        bit ovf_seq [0:DEPTH];
        m_valid = 0;
        m_busy  = 0;
        m_acc   = 0;
        m_ovf   = 0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e_rdy  = 1;
                e_done = 0;
                e_re   = 0;
                e_we   = 0;
                e_addr = 0;
                e_din  = m_acc;
                e_ovf  = int'(m_ovf);
                if (m_busy) begin
                    e_rdy = 0;
                    if (m_r <= 2 * m_n) begin
                        kc = (m_r - 1) / 2;
                        if (m_r % 2 == 1) begin
                            e_re   = 1;
                            e_addr = (m_base + kc) % DEPTH;
                        end
                    end else begin
                        kc = m_n;
                        if (m_r == 2 * m_n + 1) begin
                            e_we   = 1;
                            e_addr = m_dest;
                        end else begin
                            e_done = 1;
                        end
                    end
                    e_din = acc_seq[kc];
                    e_ovf = int'(ovf_seq[kc]);
                end
                chk("ready", 32'(ready), e_rdy);
                chk("done", 32'(done), e_done);
                chk("read_enable", 32'(re), e_re);
                chk("write_enable", 32'(we), e_we);
                chk("address", 32'(addr), e_addr);
                chk("data_in", 32'(wdata), e_din);
                chk("overflow", 32'(ovf), e_ovf);
            end
            if (rst) begin
                m_valid = 1;
                m_busy  = 0;
                m_acc   = 0;
                m_ovf   = 0;
            end else if (m_valid) begin
                if (!m_busy) begin
                    if (start) begin
                        m_n        = int'(count);
                        m_base     = int'(base);
                        m_dest     = int'(dest);
                        m_mode     = mode;
                        a          = 0;
                        o          = 0;
                        acc_seq[0] = 0;
                        ovf_seq[0] = 0;
                        for (int k = 0; k < m_n; k++) begin
                            d = int'(mem[(m_base + k) % DEPTH]);
                            if (m_mode == 1'b0) begin
                                s = a + d;
                                if (s > 65535) begin
                                    o = 1;
`ifdef MEM_ACCUM_SAT_EN
                                    a = 65535;
`else
                                    a = s - 65536;
`endif
                                end else begin
                                    a = s;
                                end
                            end else if (d > a) begin
                                a = d;
                            end
                            acc_seq[k+1] = a;
                            ovf_seq[k+1] = o;
                        end
                        m_busy = 1;
                        m_r    = 1;
                    end
                end else if (m_r == 2 * m_n + 2) begin
                    m_busy = 0;
                    m_acc  = acc_seq[m_n];
                    m_ovf  = ovf_seq[m_n];
                end else begin
                    m_r++;
                end
            end
        end
    end

    // lat = cycles from accept to Done, -2 when aborted by reset, -1 on timeout.
    task automatic run_op(input int b, input int c, input int ds, input bit md,
                          input int abort_at, input bit noise, output int lat);
        int k;
        @(posedge clk);
        #1;
        base  = AW'(b);
        count = (AW + 1)'(c);
        dest  = AW'(ds);
        mode  = md;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k     = 1;
        lat   = -1;
        while (k < 200) begin
            if (done) begin
                lat = k;
                break;
            end
            if (abort_at == k) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                chk("abort_ready", 32'(ready), 1);
                chk("abort_done", 32'(done), 0);
                lat = -2;
                return;
            end
            if (noise) begin
                start = ($urandom % 3 == 0);
                base  = AW'($urandom);
                count = (AW + 1)'($urandom_range(32, 0));
                dest  = AW'($urandom);
                mode  = 1'($urandom);
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        if (lat < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            chk("ready_after_done", 32'(ready), 1);
        end
    endtask

    initial begin : stim
        int lat, re0, we0, c, ab;
        logic [DW-1:0] exp_wrap;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_re", 32'(re), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data_in", 32'(wdata), 0);
        chk("rst_overflow", 32'(ovf), 0);

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
        run_op(0, 4, 31, 1'b0, 0, 1'b0, lat);
        chk("sum4_latency", lat, 10);
        chk("sum4_result", 32'(mem[31]), 10);
        chk("sum4_overflow", 32'(ovf), 0);

        mem[30] = 16'hFFFF;
        mem[31] = 16'h0002;
        mem[0]  = 16'h0001;
        run_op(30, 3, 25, 1'b0, 0, 1'b0, lat);
`ifdef MEM_ACCUM_SAT_EN
        exp_wrap = 16'hFFFF;
`else
        exp_wrap = 16'h0002;
`endif
        chk("wrap_result", 32'(mem[25]), 32'(exp_wrap));
        chk("wrap_overflow", 32'(ovf), 1);
        chk("wrap_latency", lat, 8);

        mem[5] = 16'h0010;
        mem[6] = 16'h8000;
        mem[7] = 16'h0300;
        run_op(5, 3, 20, 1'b1, 0, 1'b0, lat);
        chk("max_result", 32'(mem[20]), 32'h8000);
        chk("max_overflow", 32'(ovf), 0);

        mem[9] = 16'h5555;
        re0    = re_cnt;
        we0    = we_cnt;
        run_op(0, 0, 9, 1'b0, 0, 1'b0, lat);
        chk("zero_latency", lat, 2);
        chk("zero_result", 32'(mem[9]), 0);
        chk("zero_reads", re_cnt - re0, 0);
        chk("zero_writes", we_cnt - we0, 1);

        mem[3] = 16'hABCD;
        run_op(10, 8, 3, 1'b0, 6, 1'b0, lat);
        chk("abort_no_write", 32'(mem[3]), 32'hABCD);
        run_op(10, 8, 3, 1'b0, 0, 1'b0, lat);
        chk("after_abort_latency", lat, 18);
        chk("after_abort_result", 32'(mem[3]), 116);

        we0 = we_cnt;
        run_op(1, 3, 4, 1'b0, 0, 1'b1, lat);
        chk("busy_start_latency", lat, 8);
        chk("busy_start_result", 32'(mem[4]), 121);
        chk("busy_start_writes", we_cnt - we0, 1);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] = (it % 3 == 0) ? DW'($urandom_range(65535, 60000)) : DW'($urandom);
            end
            c  = $urandom_range(32, 0);
            ab = ($urandom % 5 == 0) ? $urandom_range(2 * c + 2, 1) : 0;
            run_op($urandom_range(31, 0), c, $urandom_range(31, 0), 1'($urandom), ab, 1'b1, lat);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
